output_display: RTL and testbench
=================================

Name: output_display

Overview:
- Downstream consumer of the SAP-1 output register.
- On each output-register load strobe, captures the 8-bit value and converts it to 3-digit BCD with a serial double-dabble converter.
- Drives a time-multiplexed 3-digit seven-segment display.
- Sits beside the CPU top and is fed by `cw_bus[0]` (output load) and the output register contents.

Parameters:
- REFRESH_DIV, 1000: clocks each digit stays lit before the scan advances. Legal range is ≥2.

Ports:
- clk    input   1   system clock, rising-edge.
- reset  input   1   synchronous, active-low reset.
- load   input   1   output-register load strobe. Sampled at the rising edge.
- value  input   8   unsigned value to display. Sampled with load.
- busy   output  1   conversion in progress (state ≠ IDLE).
- bcd    output  12  last completed result: {hundreds, tens, ones}, one nibble each.
- an     output  3   one-hot digit enable, active-high. an[0] = ones.
- seg    output  7   segments {g,f,e,d,c,b,a}, active-high.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, bcd=12'h000, pending cleared, refresh counter=0, digit index=0.
  - Outputs: an=3'b001, seg=7'b0111111 ("0"), busy=0.
  - Reset mid-conversion abandons the conversion and drops any pending value.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE→SHIFT: at an edge with load=1. Capture value into the shift register, clear scratch BCD, iteration count=0.
  - SHIFT: each cycle, add 3 to every scratch nibble ≥5, then shift {scratch, shift} left by 1. After the 8th shift, go to DONE.
  - DONE: copy scratch to bcd.
    - If pending is valid, load it, clear pending, and go to SHIFT.
    - Otherwise go to IDLE.
- Latency: load sampled at edge k → shifts at edges k+1..k+8 → bcd updated at edge k+9.
  - busy is high from after edge k until after edge k+9 (9 cycles).
  - Back-to-back loads through pending give a 9-cycle throughput.
- Load while busy:
  - The value goes into a one-deep pending register.
  - A further load while pending is valid overwrites it (latest wins).
  - A load in the same cycle as DONE becomes pending and starts immediately.
- bcd holds its value between conversions. No intermediate values are ever visible on bcd.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On wrap, the digit index advances 0→1→2→0 and `an` rotates 001→010→100→001.
- seg is a combinational decode of the bcd nibble selected by the current digit index.
  - Codes 0-9 use the standard patterns.
  - Nibble values 10-15 are unreachable. Decode them to blank (7'b0000000).
- The display updates within the same cycle that bcd changes. No tearing control is required.

Optional Feature:
- Macro: OUTPUT_DISPLAY_BLANK_EN.
- Defined: leading-zero blanking.
  - The hundreds digit is blanked when the hundreds nibble is 0.
  - The tens digit is blanked when the hundreds and tens nibbles are both 0.
  - The ones digit is never blanked.
  - `an` scanning is unchanged; only seg is forced to 7'b0000000 for blanked digits.
- Undefined: all three digits are always shown, including leading zeros. Reset shows "000".

Decomposition:
- Package sap1_display_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the 7-bit segment constants SEG_0..SEG_9 and SEG_BLANK;
  - the localparam for digit count (3).
- One sub-module, bin_to_bcd:
  - owns the FSM, the shift/scratch registers, the iteration counter and the pending register;
  - exposes start, din, busy, done_pulse and result.
- The top contains the refresh counter, scan and decode.

Test Plan:
- Reset low for 2 cycles:
  - bcd=000, an=001, seg=0111111, busy=0.
  - Release, then hold 50 cycles: no change other than the scan.
- load=1, value=8'd255 at edge k:
  - busy=1 for edges k+1..k+9, bcd=12'h255 after edge k+9, busy=0 after.
  - Repeat with value=8'd0 → 12'h000 and value=8'd9 → 12'h009.
- Pending loads during conversion:
  - Load 137, then at k+3 load 42, then at k+4 load 200.
  - Required: bcd=12'h137 at k+9, then 12'h200 at k+18. The value 42 is never shown. busy stays high continuously k+1..k+18.
- REFRESH_DIV=4, bcd=12'h381:
  - an sequence is 001,010,100,001, each held exactly 4 cycles.
  - seg sequence is SEG_1, SEG_8, SEG_3.
- Reset asserted at k+5 of a conversion of 99 with a pending 77:
  - The next cycle shows busy=0 and bcd=000.
  - No later completion occurs within 20 cycles.
- With OUTPUT_DISPLAY_BLANK_EN and value=7:
  - Hundreds and tens digits show seg=0000000, ones shows SEG_7.
  - value=105 shows all three digits, with the middle digit showing "0".

Source files
------------

// File: rtl/sap1_display_pkg.sv
// Shared types and constants for the SAP-1 output display: FSM states,
// seven-segment patterns ({g,f,e,d,c,b,a}, active-high) and digit count.
package sap1_display_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/output_display_bin_to_bcd.sv
// Serial double-dabble converter (8-bit binary -> 3 BCD nibbles) with a
// one-deep, latest-wins pending slot. result is valid while done_pulse is high.
module bin_to_bcd
  import sap1_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  din,
  output logic        busy,
  output logic        done_pulse,
  output logic [11:0] result
);

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] scratch_q, scratch_d, adj;
  logic [2:0]  iter_q, iter_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  pend_val_q, pend_val_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      iter_q     <= '0;
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      iter_q     <= iter_d;
      pend_vld_q <= pend_vld_d;
      pend_val_q <= pend_val_d;
    end
  end

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (scratch_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    iter_d     = iter_q;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          shift_d   = din;
          scratch_d = '0;
          iter_d    = '0;
        end
      end
      SHIFT: begin
        {scratch_d, shift_d} = {adj[10:0], shift_q, 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = DONE;
        if (start) begin
          pend_vld_d = 1'b1;
          pend_val_d = din;
        end
      end
      DONE: begin
        // A load arriving in DONE is newer than any pending value, so it wins.
        if (start || pend_vld_q) begin
          state_d    = SHIFT;
          shift_d    = start ? din : pend_val_q;
          scratch_d  = '0;
          iter_d     = '0;
          pend_vld_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign done_pulse = (state_q == DONE);
  assign result     = scratch_q;

endmodule

// File: rtl/output_display.sv
// SAP-1 output display: captures output-register loads, converts to BCD and
// scans a 3-digit seven-segment display. OUTPUT_DISPLAY_BLANK_EN enables
// leading-zero blanking.
module output_display
  import sap1_display_pkg::*;
#(
  parameter int REFRESH_DIV = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [7:0]  value,
  output logic        busy,
  output logic [11:0] bcd,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic        done_pulse;
  logic [11:0] result;
  logic [CW-1:0] ref_cnt;
  logic [1:0]  dig_idx;
  logic [NUM_DIGITS-1:0]      blank;
  logic [NUM_DIGITS-1:0][6:0] dig_seg;

  bin_to_bcd u_conv (
    .clk        (clk),
    .reset      (reset),
    .start      (load),
    .din        (value),
    .busy       (busy),
    .done_pulse (done_pulse),
    .result     (result)
  );

  always_ff @(posedge clk) begin
    if (!reset)          bcd <= '0;
    else if (done_pulse) bcd <= result;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ref_cnt <= '0;
      dig_idx <= '0;
    end else if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      dig_idx <= (dig_idx == 2'd2) ? 2'd0 : dig_idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

`ifdef OUTPUT_DISPLAY_BLANK_EN
  assign blank = {bcd[11:8] == 4'd0, bcd[11:4] == 8'd0, 1'b0};
`else
  assign blank = '0;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    assign dig_seg[g] = blank[g] ? SEG_BLANK : seg_decode(bcd[g*4 +: 4]);
  end

  assign an = 3'(3'b001 << dig_idx);

  always_comb begin
    seg = SEG_BLANK;
    case (dig_idx)
      2'd0:    seg = dig_seg[0];
      2'd1:    seg = dig_seg[1];
      2'd2:    seg = dig_seg[2];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: tb/tb_output_display.sv
// Directed bench for output_display: reset, conversion latency, pending loads,
// digit scan/decode (REFRESH_DIV=4) and reset abort.
module tb_output_display;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  value = 8'd0;
  logic        busy;
  logic [11:0] bcd;
  logic [2:0]  an;
  logic [6:0]  seg;

  int n_cmp = 0;
  int n_bad = 0;

  output_display #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .value (value),
    .busy  (busy),
    .bcd   (bcd),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  logic [6:0] segtab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                              7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                              7'b1111111, 7'b1101111};

  typedef struct {
    logic [7:0]  v;
    logic [11:0] b;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] exp_seg(input logic [11:0] b, input int d);
    logic [3:0] nib;
    logic       blk;
    nib = b[d*4 +: 4];
    blk = 1'b0;
`ifdef OUTPUT_DISPLAY_BLANK_EN
    if (d == 2 && b[11:8] == 4'd0) blk = 1'b1;
    if (d == 1 && b[11:4] == 8'd0) blk = 1'b1;
`endif
    if (blk || nib > 4'd9) return 7'b0000000;
    return segtab[nib];
  endfunction

  task automatic run_conv(input logic [7:0] v, input logic [11:0] exp, input logic [11:0] old);
    load = 1'b1; value = v;
    tick();
    load = 1'b0;
    chk("busy_after_load", busy, 1);
    chk("bcd_hold", bcd, old);
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("busy_mid", busy, 1);
      chk("bcd_hold", bcd, old);
    end
    tick();
    chk("busy_done", busy, 0);
    chk("bcd_result", bcd, exp);
  endtask

  task automatic scan_check(input logic [11:0] b);
    logic [2:0] prev;
    int w, d0, di;
    prev = an;
    w = 0;
    while (an == prev && w < 8) begin
      tick();
      w++;
    end
    if (an == prev) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scan_timeout: an stuck at %b, required a change within 8 cycles", an);
      return;
    end
    d0 = an[0] ? 0 : (an[1] ? 1 : 2);
    for (int c = 0; c < 12; c++) begin
      di = (d0 + c / 4) % 3;
      chk("scan_an", an, 32'(3'b001 << di));
      chk("scan_seg", seg, exp_seg(b, di));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] old;
    logic [11:0] e;

    vecs[0] = '{8'd255, 12'h255};
    vecs[1] = '{8'd0,   12'h000};
    vecs[2] = '{8'd9,   12'h009};
    vecs[3] = '{8'd7,   12'h007};
    vecs[4] = '{8'd105, 12'h105};
    vecs[5] = '{8'd183, 12'h183};

    reset = 1'b0;
    tick();
    tick();
    chk("rst_bcd", bcd, 12'h000);
    chk("rst_an", an, 3'b001);
    chk("rst_seg", seg, 7'b0111111);
    chk("rst_busy", busy, 0);
    reset = 1'b1;

    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_bcd", bcd, 12'h000);
      chk("idle_busy", busy, 0);
    end

    old = 12'h000;
    for (int i = 0; i < 6; i++) begin
      run_conv(vecs[i].v, vecs[i].b, old);
      scan_check(vecs[i].b);
      old = vecs[i].b;
    end

    // 137, then 42 and 200 while busy: 42 is overwritten by 200.
    for (int off = 0; off <= 18; off++) begin
      load  = (off == 0 || off == 3 || off == 4);
      value = (off == 0) ? 8'd137 : (off == 3) ? 8'd42 : 8'd200;
      tick();
      load = 1'b0;
      e = (off < 9) ? old : (off < 18) ? 12'h137 : 12'h200;
      chk("pend_busy", busy, (off < 18) ? 1 : 0);
      chk("pend_bcd", bcd, e);
    end

    // Reset during conversion of 99 with 77 pending.
    for (int off = 0; off <= 5; off++) begin
      load  = (off == 0 || off == 2);
      value = (off == 0) ? 8'd99 : 8'd77;
      reset = (off == 5) ? 1'b0 : 1'b1;
      tick();
      load = 1'b0;
      if (off < 5) chk("abort_busy_pre", busy, 1);
    end
    reset = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_bcd", bcd, 12'h000);
    chk("abort_an", an, 3'b001);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("abort_quiet_busy", busy, 0);
      chk("abort_quiet_bcd", bcd, 12'h000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
